// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage (master) and its PC, memory and decoder (slave).
interface instr_fetch_if;
  logic        start_i;
  logic        busy_o;
  logic [15:0] pc_addr_i;
  logic        pc_inc_o;
  logic [15:0] mem_addr_o;
  logic        mem_rd_o;
  logic        mem_rdy_i;
  logic [7:0]  mem_dat_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [7:0]  opcode_o;
  logic [15:0] operand_o;
  logic [1:0]  instr_len_o;
  logic [15:0] instr_addr_o;
  logic        fetch_err_o;

  modport master (
    input  start_i, pc_addr_i, mem_rdy_i, mem_dat_i, instr_ready_i,
    output busy_o, pc_inc_o, mem_addr_o, mem_rd_o, instr_valid_o,
           opcode_o, operand_o, instr_len_o, instr_addr_o, fetch_err_o
  );

  modport slave (
    output start_i, pc_addr_i, mem_rdy_i, mem_dat_i, instr_ready_i,
    input  busy_o, pc_inc_o, mem_addr_o, mem_rd_o, instr_valid_o,
           opcode_o, operand_o, instr_len_o, instr_addr_o, fetch_err_o
  );
endinterface

// File: rtl/instr_fetch.sv
// 8080 instruction fetch stage: reads opcode plus immediates, pulses the PC per byte.
// Optional memory-wait timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int PC_SETTLE      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk50M_i,
  input logic           rst_i,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    INC    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_r;
  logic [1:0]  idx_r;
  logic [3:0]  settle_r;
  logic        busy_r;
  logic        pc_inc_r;
  logic        mem_rd_r;
  logic        valid_r;
  logic [15:0] mem_addr_r;
  logic [15:0] operand_r;
  logic [15:0] instr_addr_r;
  logic [7:0]  opcode_r;
  logic [1:0]  len_r;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt_r;
  logic          err_r;
`endif

  // Instruction length in bytes derived from the opcode
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len_s;
    if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
                   8'hC3, 8'hCB, 8'hCD, 8'hDD, 8'hED, 8'hFD}) begin
      len_s = 2'd3;
    end else if (op[7:6] == 2'b11 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)) begin
      len_s = 2'd3;
    end else if (op == 8'hD3 || op == 8'hDB) begin
      len_s = 2'd2;
    end else if (op[2:0] == 3'b110 && (op[7:6] == 2'b00 || op[7:6] == 2'b11)) begin
      len_s = 2'd2;
    end else begin
      len_s = 2'd1;
    end
    return len_s;
  endfunction

  // Fetch sequencer with all outputs registered
  always_ff @(posedge clk50M_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      idx_r        <= 2'd0;
      settle_r     <= 4'd0;
      busy_r       <= 1'b0;
      pc_inc_r     <= 1'b0;
      mem_rd_r     <= 1'b0;
      valid_r      <= 1'b0;
      mem_addr_r   <= 16'd0;
      operand_r    <= 16'd0;
      instr_addr_r <= 16'd0;
      opcode_r     <= 8'd0;
      len_r        <= 2'd0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt_r     <= '0;
      err_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          pc_inc_r <= 1'b0;
          valid_r  <= 1'b0;
          if (bus.start_i) begin
            mem_addr_r   <= bus.pc_addr_i;
            instr_addr_r <= bus.pc_addr_i;
            operand_r    <= 16'd0;
            idx_r        <= 2'd0;
            busy_r       <= 1'b1;
            mem_rd_r     <= 1'b1;
            state_r      <= RD;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_r     <= '0;
            err_r        <= 1'b0;
`endif
          end else begin
            busy_r   <= 1'b0;
            mem_rd_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RD: begin
          if (bus.mem_rdy_i) begin
            case (idx_r)
              2'd0: begin
                opcode_r <= bus.mem_dat_i;
                len_r    <= op_len(bus.mem_dat_i);
              end
              2'd1:    operand_r[7:0]  <= bus.mem_dat_i;
              2'd2:    operand_r[15:8] <= bus.mem_dat_i;
              default: operand_r       <= operand_r;
            endcase
            idx_r    <= idx_r + 2'd1;
            mem_rd_r <= 1'b0;
            pc_inc_r <= 1'b1;
            state_r  <= INC;
`ifdef FETCH_TIMEOUT_EN
          end else if (to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
            // Give up on this byte: no PC pulse, no instruction
            mem_rd_r <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b1;
            state_r  <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
            state_r  <= RD;
          end
`else
          end else begin
            state_r <= RD;
          end
`endif
        end
        INC: begin
          pc_inc_r <= 1'b0;
          settle_r <= 4'(PC_SETTLE);
          state_r  <= SETTLE;
        end
        SETTLE: begin
          if (settle_r == 4'd1) begin
            if (idx_r == len_r) begin
              valid_r <= 1'b1;
              state_r <= DONE;
            end else begin
              // PC has advanced by now, so it addresses the next byte
              mem_addr_r <= bus.pc_addr_i;
              mem_rd_r   <= 1'b1;
              state_r    <= RD;
`ifdef FETCH_TIMEOUT_EN
              to_cnt_r   <= '0;
`endif
            end
          end else begin
            settle_r <= settle_r - 4'd1;
          end
        end
        DONE: begin
          if (bus.instr_ready_i) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          busy_r   <= 1'b0;
          pc_inc_r <= 1'b0;
          mem_rd_r <= 1'b0;
          valid_r  <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o        = busy_r;
  assign bus.pc_inc_o      = pc_inc_r;
  assign bus.mem_addr_o    = mem_addr_r;
  assign bus.mem_rd_o      = mem_rd_r;
  assign bus.instr_valid_o = valid_r;
  assign bus.opcode_o      = opcode_r;
  assign bus.operand_o     = operand_r;
  assign bus.instr_len_o   = len_r;
  assign bus.instr_addr_o  = instr_addr_r;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err_o   = err_r;
`else
  assign bus.fetch_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetches
// against a memory/PC/length-table reference model.
module tb_instr_fetch;
  localparam int PC_SETTLE      = 2;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int STEP           = 2 + PC_SETTLE;

  logic clk50M_i = 1'b0;
  logic rst_i;
  instr_fetch_if ifc();

  instr_fetch #(.PC_SETTLE(PC_SETTLE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk50M_i(clk50M_i),
    .rst_i   (rst_i),
    .bus     (ifc)
  );

  always #10 clk50M_i = ~clk50M_i;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc;
  int          n_inc;
  int          n_cmp;
  int          n_fail;
  int          wait_cfg;
  bit          mem_dead;
  int          len_tab [256];

  assign ifc.pc_addr_i = pc;

  // Program counter model: advances once per increment strobe
  initial begin
    pc = 16'h0000;
    n_inc = 0;
    forever begin
      @(negedge clk50M_i);
      if (ifc.pc_inc_o === 1'b1) begin
        pc = pc + 16'd1;
        n_inc++;
      end
    end
  end

  // Memory responder with configurable wait states
  initial begin
    int waited;
    logic [15:0] last_addr;
    bit was_rd;
    waited = 0;
    was_rd = 1'b0;
    last_addr = 16'h0000;
    ifc.mem_rdy_i = 1'b0;
    ifc.mem_dat_i = 8'h00;
    forever begin
      @(negedge clk50M_i);
      if (ifc.mem_rd_o === 1'b1) begin
        if (was_rd && ifc.mem_rdy_i === 1'b0) begin
          n_cmp++;
          if (ifc.mem_addr_o !== last_addr) begin
            n_fail++;
            $display("FAIL addr_stable: mem_addr_o=%h required %h", ifc.mem_addr_o, last_addr);
          end
        end
        last_addr = ifc.mem_addr_o;
        was_rd = 1'b1;
        if (!mem_dead && waited >= wait_cfg) begin
          ifc.mem_rdy_i = 1'b1;
          ifc.mem_dat_i = mem[ifc.mem_addr_o];
        end else begin
          ifc.mem_rdy_i = 1'b0;
          ifc.mem_dat_i = 8'($urandom);
          waited++;
        end
      end else begin
        ifc.mem_rdy_i = 1'b0;
        waited = 0;
        was_rd = 1'b0;
      end
    end
  end

  function automatic logic [15:0] exp_operand(input logic [15:0] a, input int len);
    logic [15:0] r;
    r = 16'h0000;
    if (len >= 2) r[7:0]  = mem[a + 16'd1];
    if (len == 3) r[15:8] = mem[a + 16'd2];
    return r;
  endfunction

  // Launch a fetch at pc0; returns the cycle instr_valid_o was seen (-1 if never)
  task automatic do_fetch(input logic [15:0] pc0, output int cyc);
    @(negedge clk50M_i);
    pc = pc0;
    ifc.start_i = 1'b1;
    @(posedge clk50M_i);
    @(negedge clk50M_i);
    ifc.start_i = 1'b0;
    cyc = 1;
    while (ifc.instr_valid_o !== 1'b1 && cyc < 400) begin
      @(negedge clk50M_i);
      cyc++;
    end
    if (ifc.instr_valid_o !== 1'b1) cyc = -1;
  endtask

  task automatic accept();
    ifc.instr_ready_i = 1'b1;
    @(posedge clk50M_i);
    @(negedge clk50M_i);
    ifc.instr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [62:0] outs;
    rst_i = 1'b1;
    repeat (2) @(negedge clk50M_i);
    outs = {ifc.busy_o, ifc.pc_inc_o, ifc.mem_rd_o, ifc.mem_addr_o, ifc.instr_valid_o,
            ifc.opcode_o, ifc.operand_o, ifc.instr_len_o, ifc.instr_addr_o, ifc.fetch_err_o};
    n_cmp++;
    if (outs !== 63'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk50M_i);
    n_cmp++;
    if (ifc.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy_o=%b required 0", ifc.busy_o);
    end
  endtask

  task automatic test_nop();
    int cyc, inc0;
    mem[16'h0100] = 8'h00;
    wait_cfg = 0;
    inc0 = n_inc;
    do_fetch(16'h0100, cyc);
    n_cmp++;
    if (cyc !== 1 + STEP) begin n_fail++; $display("FAIL nop_latency: cycle %0d required %0d", cyc, 1 + STEP); end
    n_cmp++;
    if ({ifc.opcode_o, ifc.instr_len_o, ifc.operand_o, ifc.instr_addr_o} !== {8'h00, 2'd1, 16'h0000, 16'h0100}) begin
      n_fail++;
      $display("FAIL nop_instr: op=%h len=%0d opd=%h addr=%h required 00/1/0000/0100",
               ifc.opcode_o, ifc.instr_len_o, ifc.operand_o, ifc.instr_addr_o);
    end
    n_cmp++;
    if (n_inc - inc0 !== 1) begin n_fail++; $display("FAIL nop_pulses: got %0d required 1", n_inc - inc0); end
    accept();
    n_cmp++;
    if ({ifc.instr_valid_o, ifc.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL nop_release: valid=%b busy=%b required 0 0", ifc.instr_valid_o, ifc.busy_o);
    end
  endtask

  task automatic test_mvi();
    int cyc, inc0;
    mem[16'h0200] = 8'h3E;
    mem[16'h0201] = 8'h42;
    inc0 = n_inc;
    do_fetch(16'h0200, cyc);
    n_cmp++;
    if (cyc !== 1 + 2 * STEP) begin n_fail++; $display("FAIL mvi_latency: cycle %0d required %0d", cyc, 1 + 2 * STEP); end
    n_cmp++;
    if ({ifc.opcode_o, ifc.instr_len_o, ifc.operand_o} !== {8'h3E, 2'd2, 16'h0042}) begin
      n_fail++;
      $display("FAIL mvi_instr: op=%h len=%0d opd=%h required 3E/2/0042", ifc.opcode_o, ifc.instr_len_o, ifc.operand_o);
    end
    n_cmp++;
    if (n_inc - inc0 !== 2 || pc !== 16'h0202) begin
      n_fail++;
      $display("FAIL mvi_pulses: got %0d pc=%h required 2 pc=0202", n_inc - inc0, pc);
    end
    accept();
  endtask

  task automatic test_jmp_wait();
    int cyc, inc0;
    mem[16'h0300] = 8'hC3;
    mem[16'h0301] = 8'h00;
    mem[16'h0302] = 8'h20;
    wait_cfg = 3;
    inc0 = n_inc;
    do_fetch(16'h0300, cyc);
    wait_cfg = 0;
    n_cmp++;
    if (cyc !== 1 + 3 * (STEP + 3)) begin n_fail++; $display("FAIL jmp_latency: cycle %0d required %0d", cyc, 1 + 3 * (STEP + 3)); end
    n_cmp++;
    if ({ifc.opcode_o, ifc.instr_len_o, ifc.operand_o} !== {8'hC3, 2'd3, 16'h2000}) begin
      n_fail++;
      $display("FAIL jmp_instr: op=%h len=%0d opd=%h required C3/3/2000", ifc.opcode_o, ifc.instr_len_o, ifc.operand_o);
    end
    n_cmp++;
    if (n_inc - inc0 !== 3) begin n_fail++; $display("FAIL jmp_pulses: got %0d required 3", n_inc - inc0); end
    accept();
  endtask

  task automatic test_backpressure();
    int cyc, inc0;
    logic [58:0] held;
    mem[16'h0400] = 8'h06;
    mem[16'h0401] = 8'h55;
    inc0 = n_inc;
    do_fetch(16'h0400, cyc);
    for (int i = 0; i < 10; i++) begin
      ifc.start_i = (i == 3) ? 1'b1 : 1'b0;
      pc = 16'h7000;
      held = {ifc.instr_valid_o, ifc.busy_o, ifc.opcode_o, ifc.instr_len_o, ifc.operand_o, ifc.instr_addr_o};
      n_cmp++;
      if (held !== {1'b1, 1'b1, 8'h06, 2'd2, 16'h0055, 16'h0400}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h required %h", i, held, {1'b1, 1'b1, 8'h06, 2'd2, 16'h0055, 16'h0400});
      end
      @(negedge clk50M_i);
    end
    ifc.start_i = 1'b0;
    accept();
    n_cmp++;
    if ({ifc.instr_valid_o, ifc.busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b busy=%b required 0 0", ifc.instr_valid_o, ifc.busy_o);
    end
    repeat (3) @(negedge clk50M_i);
    n_cmp++;
    if (ifc.busy_o !== 1'b0 || n_inc - inc0 !== 2) begin
      n_fail++;
      $display("FAIL bp_start_ignored: busy=%b pulses=%0d required 0 and 2", ifc.busy_o, n_inc - inc0);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, inc0, guard;
    logic [62:0] outs;
    mem[16'h0500] = 8'hCD;
    mem[16'h0501] = 8'h34;
    mem[16'h0502] = 8'h12;
    inc0 = n_inc;
    @(negedge clk50M_i);
    pc = 16'h0500;
    ifc.start_i = 1'b1;
    @(negedge clk50M_i);
    ifc.start_i = 1'b0;
    guard = 0;
    while (n_inc - inc0 < 2 && guard < 100) begin
      @(negedge clk50M_i);
      guard++;
    end
    @(negedge clk50M_i);
    rst_i = 1'b1;
    #1;
    outs = {ifc.busy_o, ifc.pc_inc_o, ifc.mem_rd_o, ifc.mem_addr_o, ifc.instr_valid_o,
            ifc.opcode_o, ifc.operand_o, ifc.instr_len_o, ifc.instr_addr_o, ifc.fetch_err_o};
    n_cmp++;
    if (outs !== 63'd0) begin n_fail++; $display("FAIL midreset_outputs: got %h required 0", outs); end
    repeat (3) @(negedge clk50M_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk50M_i);
    n_cmp++;
    if (n_inc - inc0 !== 2 || ifc.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abort: pulses=%0d busy=%b required 2 and 0", n_inc - inc0, ifc.busy_o);
    end
    mem[16'h0600] = 8'h3A;
    mem[16'h0601] = 8'h78;
    mem[16'h0602] = 8'h56;
    inc0 = n_inc;
    do_fetch(16'h0600, cyc);
    n_cmp++;
    if (cyc !== 1 + 3 * STEP || {ifc.opcode_o, ifc.operand_o, ifc.instr_len_o} !== {8'h3A, 16'h5678, 2'd3}
        || n_inc - inc0 !== 3) begin
      n_fail++;
      $display("FAIL midreset_refetch: cyc=%0d op=%h opd=%h len=%0d pulses=%0d required 13/3A/5678/3/3",
               cyc, ifc.opcode_o, ifc.operand_o, ifc.instr_len_o, n_inc - inc0);
    end
    accept();
  endtask

  task automatic test_random();
    int cyc, inc0, len, dly, wc;
    logic [15:0] pc0, opd;
    logic [7:0] op;
    for (int i = 0; i < 40; i++) begin
      pc0 = (i % 5 == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      op = 8'($urandom);
      mem[pc0] = op;
      mem[pc0 + 16'd1] = 8'($urandom);
      mem[pc0 + 16'd2] = 8'($urandom);
      len = len_tab[op];
      opd = exp_operand(pc0, len);
      wc = (i % 2 == 1) ? $urandom_range(0, 3) : 0;
      wait_cfg = wc;
      inc0 = n_inc;
      do_fetch(pc0, cyc);
      wait_cfg = 0;
      n_cmp++;
      if (cyc < 0 || (wc == 0 && cyc != 1 + len * STEP)) begin
        n_fail++;
        $display("FAIL rnd_latency[%0d]: cycle %0d required %0d", i, cyc, 1 + len * STEP);
      end
      dly = $urandom_range(0, 3);
      repeat (dly) @(negedge clk50M_i);
      n_cmp++;
      if ({ifc.instr_valid_o, ifc.opcode_o, ifc.instr_len_o, ifc.operand_o, ifc.instr_addr_o}
          !== {1'b1, op, 2'(len), opd, pc0}) begin
        n_fail++;
        $display("FAIL rnd_instr[%0d]: op=%h len=%0d opd=%h addr=%h required %h/%0d/%h/%h",
                 i, ifc.opcode_o, ifc.instr_len_o, ifc.operand_o, ifc.instr_addr_o, op, len, opd, pc0);
      end
      n_cmp++;
      if (n_inc - inc0 !== len || pc !== pc0 + 16'(len)) begin
        n_fail++;
        $display("FAIL rnd_pulses[%0d]: got %0d pc=%h required %0d pc=%h", i, n_inc - inc0, pc, len, pc0 + 16'(len));
      end
      accept();
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, inc0;
    mem_dead = 1'b1;
    inc0 = n_inc;
    @(negedge clk50M_i);
    pc = 16'h0700;
    ifc.start_i = 1'b1;
    @(negedge clk50M_i);
    ifc.start_i = 1'b0;
    cyc = 1;
    while (ifc.busy_o === 1'b1 && cyc < 400) begin
      @(negedge clk50M_i);
      cyc++;
    end
    n_cmp++;
    if (cyc !== 1 + TIMEOUT_CYCLES) begin n_fail++; $display("FAIL to_latency: cycle %0d required %0d", cyc, 1 + TIMEOUT_CYCLES); end
    repeat (3) @(negedge clk50M_i);
    n_cmp++;
    if ({ifc.fetch_err_o, ifc.busy_o, ifc.mem_rd_o, ifc.instr_valid_o} !== 4'b1000 || n_inc - inc0 !== 0) begin
      n_fail++;
      $display("FAIL to_state: err=%b busy=%b rd=%b valid=%b pulses=%0d required 1 0 0 0 0",
               ifc.fetch_err_o, ifc.busy_o, ifc.mem_rd_o, ifc.instr_valid_o, n_inc - inc0);
    end
    mem_dead = 1'b0;
    mem[16'h0700] = 8'h00;
    do_fetch(16'h0700, cyc);
    n_cmp++;
    if (ifc.fetch_err_o !== 1'b0 || ifc.opcode_o !== 8'h00 || cyc !== 1 + STEP) begin
      n_fail++;
      $display("FAIL to_recover: err=%b op=%h cyc=%0d required 0 00 %0d", ifc.fetch_err_o, ifc.opcode_o, cyc, 1 + STEP);
    end
    accept();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    wait_cfg = 0;
    mem_dead = 1'b0;
    rst_i = 1'b1;
    ifc.start_i = 1'b0;
    ifc.instr_ready_i = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int b = 0; b < 256; b++) len_tab[b] = 1;
    for (int r = 0; r < 8; r++) begin
      len_tab[8'h06 + 8 * r] = 2;
      len_tab[8'hC6 + 8 * r] = 2;
      len_tab[8'hC2 + 8 * r] = 3;
      len_tab[8'hC4 + 8 * r] = 3;
    end
    len_tab[8'hD3] = 2;
    len_tab[8'hDB] = 2;
    foreach (len_tab[k]) begin
      if (k inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
                    8'hC3, 8'hCB, 8'hCD, 8'hDD, 8'hED, 8'hFD}) len_tab[k] = 3;
    end

    test_reset();
    test_nop();
    test_mvi();
    test_jmp_wait();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
